// File: rtl/udseq_pkg.sv
// Shared types and default widths for the up/down count sequencer.
// Optional build macro used by this slice: UDSEQ_AUTORELOAD_EN.
package udseq_pkg;

  localparam int unsigned UDSEQ_W     = 32;
  localparam int unsigned UDSEQ_REP_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } udseq_state_e;

endpackage

// File: rtl/updown_count_sequencer_if.sv
// Command handshake bundle: the control layer is master, the sequencer is slave.
interface updown_count_sequencer_if
  import udseq_pkg::*;
#(
  parameter int unsigned W     = UDSEQ_W,
  parameter int unsigned REP_W = UDSEQ_REP_W
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [W-1:0]     cmd_start;
  logic [W-1:0]     cmd_limit;
  logic             cmd_up;
  logic [REP_W-1:0] cmd_reps;

  modport master (
    output cmd_valid, cmd_start, cmd_limit, cmd_up, cmd_reps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_limit, cmd_up, cmd_reps,
    output cmd_ready
  );

endinterface

// File: rtl/udseq_counter.sv
// W-bit up/down counter datapath; load has priority over count enable.
module udseq_counter
  import udseq_pkg::*;
#(
  parameter int unsigned W = UDSEQ_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] STEP_ONE = W'(1);

  logic [W-1:0] count_r;

  // Counter register: wraps modulo 2^W in either direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en) begin
      if (up) begin
        count_r <= count_r + STEP_ONE;
      end else begin
        count_r <= count_r - STEP_ONE;
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/updown_count_sequencer.sv
// Sequences udseq_counter through programmed runs of passes from start to limit.
// Build macro UDSEQ_AUTORELOAD_EN adds auto_reload: restart the run after done.
module updown_count_sequencer
  import udseq_pkg::*;
#(
  parameter int unsigned W     = UDSEQ_W,
  parameter int unsigned REP_W = UDSEQ_REP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  updown_count_sequencer_if.slave  cmd,
  input  logic                     tick,
  input  logic                     abort,
`ifdef UDSEQ_AUTORELOAD_EN
  input  logic                     auto_reload,
`endif
  output logic [W-1:0]             count,
  output logic                     busy,
  output logic                     pass_done,
  output logic                     done,
  output logic                     aborted
);

  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  udseq_state_e     state_r;
  logic [W-1:0]     start_r;
  logic [W-1:0]     limit_r;
  logic             up_r;
  logic [REP_W-1:0] reps_r;
  logic [REP_W-1:0] remaining_r;
  logic             ready_r;
  logic             busy_r;
  logic             pass_done_r;
  logic             done_r;
  logic             aborted_r;

  logic [W-1:0]     count_s;
  logic             at_limit_s;
  logic             load_s;
  logic             en_s;
  logic             restart_s;
  logic [REP_W-1:0] reps_eff_s;

`ifdef UDSEQ_AUTORELOAD_EN
  assign restart_s = auto_reload;
`else
  assign restart_s = 1'b0;
`endif

  // Counter control decode; an abort suppresses both load and step.
  always_comb begin
    at_limit_s = (count_s == limit_r);
    reps_eff_s = (cmd.cmd_reps == '0) ? REP_ONE : cmd.cmd_reps;
    load_s     = 1'b0;
    en_s       = 1'b0;
    case (state_r)
      LOAD: begin
        if (!abort) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      RUN: begin
        if (!abort && tick && !at_limit_s) begin
          en_s = 1'b1;
        end else begin
          en_s = 1'b0;
        end
      end
      default: begin
        load_s = 1'b0;
        en_s   = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with command capture and registered status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      start_r     <= '0;
      limit_r     <= '0;
      up_r        <= 1'b0;
      reps_r      <= '0;
      remaining_r <= '0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      pass_done_r <= 1'b0;
      done_r      <= 1'b0;
      aborted_r   <= 1'b0;
    end else begin
      pass_done_r <= 1'b0;
      done_r      <= 1'b0;
      aborted_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd.cmd_valid) begin
            start_r     <= cmd.cmd_start;
            limit_r     <= cmd.cmd_limit;
            up_r        <= cmd.cmd_up;
            reps_r      <= reps_eff_s;
            remaining_r <= reps_eff_s;
            state_r     <= LOAD;
            ready_r     <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            aborted_r <= 1'b1;
            state_r   <= IDLE;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
          end else begin
            state_r <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            aborted_r <= 1'b1;
            state_r   <= IDLE;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
          end else if (tick && at_limit_s) begin
            pass_done_r <= 1'b1;
            if (remaining_r == REP_ONE) begin
              done_r <= 1'b1;
              if (restart_s) begin
                remaining_r <= reps_r;
                state_r     <= LOAD;
              end else begin
                remaining_r <= '0;
                state_r     <= IDLE;
                ready_r     <= 1'b1;
                busy_r      <= 1'b0;
              end
            end else begin
              remaining_r <= remaining_r - REP_ONE;
              state_r     <= LOAD;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  udseq_counter #(.W(W)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (start_r),
    .en       (en_s),
    .up       (up_r),
    .count    (count_s)
  );

  assign cmd.cmd_ready = ready_r;
  assign count         = count_s;
  assign busy          = busy_r;
  assign pass_done     = pass_done_r;
  assign done          = done_r;
  assign aborted       = aborted_r;

endmodule

// File: tb/tb_updown_count_sequencer.sv
// Directed scoreboard bench for updown_count_sequencer (UDSEQ_AUTORELOAD_EN adds a restart test).
module tb_updown_count_sequencer;

  typedef struct {
    string       tag;
    logic [36:0] val;
  } exp_t;

  // flag order: {busy, cmd_ready, pass_done, done, aborted}
  localparam logic [4:0] F_IDLE      = 5'b01000;
  localparam logic [4:0] F_BUSY      = 5'b10000;
  localparam logic [4:0] F_DONE_IDLE = 5'b01110;
  localparam logic [4:0] F_PD_LOAD   = 5'b10100;
  localparam logic [4:0] F_AB_IDLE   = 5'b01001;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        abort;
  logic [31:0] count;
  logic        busy;
  logic        pass_done;
  logic        done;
  logic        aborted;
`ifdef UDSEQ_AUTORELOAD_EN
  logic        auto_reload;
`endif

  exp_t sb_q[$];
  int   n_cmp;
  int   n_fail;

  updown_count_sequencer_if #(.W(32), .REP_W(8)) cif ();

  updown_count_sequencer #(.W(32), .REP_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cif),
    .tick        (tick),
    .abort       (abort),
`ifdef UDSEQ_AUTORELOAD_EN
    .auto_reload (auto_reload),
`endif
    .count       (count),
    .busy        (busy),
    .pass_done   (pass_done),
    .done        (done),
    .aborted     (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_front();
    exp_t        e;
    logic [36:0] obs;
    e   = sb_q.pop_front();
    obs = {count, busy, cif.cmd_ready, pass_done, done, aborted};
    n_cmp++;
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed count=%h flags=%b expected count=%h flags=%b",
             e.tag, obs[36:5], obs[4:0], e.val[36:5], e.val[4:0]);
    end
  endtask

  task automatic set_cmd(input logic [31:0] s, input logic [31:0] l, input logic u, input logic [7:0] r);
    cif.cmd_start = s;
    cif.cmd_limit = l;
    cif.cmd_up    = u;
    cif.cmd_reps  = r;
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next edge, then compare.
  task automatic step(input string tag, input logic v, input logic tk, input logic ab,
                      input logic [31:0] ec, input logic [4:0] ef);
    cif.cmd_valid = v;
    tick          = tk;
    abort         = ab;
    sb_q.push_back('{tag: tag, val: {ec, ef}});
    @(negedge clk);
    check_front();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    tick   = 1'b0;
    abort  = 1'b0;
    cif.cmd_valid = 1'b0;
    set_cmd(32'd0, 32'd0, 1'b0, 8'd0);
`ifdef UDSEQ_AUTORELOAD_EN
    auto_reload = 1'b0;
`endif
    #2;
    sb_q.push_back('{tag: "reset", val: {32'd0, F_IDLE}});
    check_front();
    @(negedge clk);
    rst = 1'b0;

    // up count 5..8, single pass
    set_cmd(32'd5, 32'd8, 1'b1, 8'd1);
    step("t1_accept", 1'b1, 1'b1, 1'b0, 32'd0, F_BUSY);
    step("t1_load",   1'b0, 1'b1, 1'b0, 32'd5, F_BUSY);
    step("t1_c6",     1'b0, 1'b1, 1'b0, 32'd6, F_BUSY);
    step("t1_c7",     1'b0, 1'b1, 1'b0, 32'd7, F_BUSY);
    step("t1_c8",     1'b0, 1'b1, 1'b0, 32'd8, F_BUSY);
    step("t1_done",   1'b0, 1'b1, 1'b0, 32'd8, F_DONE_IDLE);
    step("t1_idle",   1'b0, 1'b1, 1'b0, 32'd8, F_IDLE);

    // down count wrapping through zero
    set_cmd(32'd1, 32'hFFFF_FFFE, 1'b0, 8'd1);
    step("t2_accept", 1'b1, 1'b1, 1'b0, 32'd8, F_BUSY);
    step("t2_load",   1'b0, 1'b1, 1'b0, 32'd1, F_BUSY);
    step("t2_c0",     1'b0, 1'b1, 1'b0, 32'd0, F_BUSY);
    step("t2_cwrap",  1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, F_BUSY);
    step("t2_climit", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, F_BUSY);
    step("t2_done",   1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, F_DONE_IDLE);

    // start == limit, reps 0 treated as 1
    set_cmd(32'd3, 32'd3, 1'b1, 8'd0);
    step("t3_accept", 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, F_BUSY);
    step("t3_load",   1'b0, 1'b1, 1'b0, 32'd3, F_BUSY);
    step("t3_done",   1'b0, 1'b1, 1'b0, 32'd3, F_DONE_IDLE);
    step("t3_idle",   1'b0, 1'b1, 1'b0, 32'd3, F_IDLE);

    // three passes 0..2 with tick toggling
    set_cmd(32'd0, 32'd2, 1'b1, 8'd3);
    step("t4_accept", 1'b1, 1'b0, 1'b0, 32'd3, F_BUSY);
    step("t4_load",   1'b0, 1'b0, 1'b0, 32'd0, F_BUSY);
    for (int p = 0; p < 3; p++) begin
      step("t4_tick1", 1'b0, 1'b1, 1'b0, 32'd1, F_BUSY);
      step("t4_hold1", 1'b0, 1'b0, 1'b0, 32'd1, F_BUSY);
      step("t4_tick2", 1'b0, 1'b1, 1'b0, 32'd2, F_BUSY);
      step("t4_hold2", 1'b0, 1'b0, 1'b0, 32'd2, F_BUSY);
      if (p < 2) begin
        step("t4_pass",   1'b0, 1'b1, 1'b0, 32'd2, F_PD_LOAD);
        step("t4_reload", 1'b0, 1'b0, 1'b0, 32'd0, F_BUSY);
      end else begin
        step("t4_final",  1'b0, 1'b1, 1'b0, 32'd2, F_DONE_IDLE);
      end
    end
    step("t4_idle", 1'b0, 1'b0, 1'b0, 32'd2, F_IDLE);

    // abort on the second RUN cycle, then abort ignored in IDLE
    set_cmd(32'd10, 32'd20, 1'b1, 8'd2);
    step("t5_accept", 1'b1, 1'b1, 1'b0, 32'd2, F_BUSY);
    step("t5_load",   1'b0, 1'b1, 1'b0, 32'd10, F_BUSY);
    step("t5_c11",    1'b0, 1'b1, 1'b0, 32'd11, F_BUSY);
    step("t5_abort",  1'b0, 1'b1, 1'b1, 32'd11, F_AB_IDLE);
    step("t5_frozen", 1'b0, 1'b1, 1'b0, 32'd11, F_IDLE);
    step("t5_idleab", 1'b0, 1'b1, 1'b1, 32'd11, F_IDLE);

    // abort in LOAD while valid stays high; valid is taken only once back in IDLE
    set_cmd(32'd11, 32'd13, 1'b1, 8'd1);
    step("t6_accept", 1'b1, 1'b1, 1'b0, 32'd11, F_BUSY);
    step("t6_ldabort",1'b1, 1'b1, 1'b1, 32'd11, F_AB_IDLE);
    step("t6_reacc",  1'b1, 1'b1, 1'b0, 32'd11, F_BUSY);
    step("t6_load",   1'b0, 1'b1, 1'b0, 32'd11, F_BUSY);
    step("t6_c12",    1'b0, 1'b1, 1'b0, 32'd12, F_BUSY);
    step("t6_c13",    1'b0, 1'b1, 1'b0, 32'd13, F_BUSY);
    step("t6_done",   1'b0, 1'b1, 1'b0, 32'd13, F_DONE_IDLE);

    // asynchronous reset in the middle of a run
    set_cmd(32'd100, 32'd200, 1'b1, 8'd1);
    step("t7_accept", 1'b1, 1'b1, 1'b0, 32'd13, F_BUSY);
    step("t7_load",   1'b0, 1'b1, 1'b0, 32'd100, F_BUSY);
    step("t7_c101",   1'b0, 1'b1, 1'b0, 32'd101, F_BUSY);
    #2;
    rst = 1'b1;
    #1;
    sb_q.push_back('{tag: "t7_rst_async", val: {32'd0, F_IDLE}});
    check_front();
    @(negedge clk);
    sb_q.push_back('{tag: "t7_rst_held", val: {32'd0, F_IDLE}});
    check_front();
    rst = 1'b0;
    step("t7_post",   1'b0, 1'b1, 1'b0, 32'd0, F_IDLE);

`ifdef UDSEQ_AUTORELOAD_EN
    // auto reload restarts the run after done until aborted
    auto_reload = 1'b1;
    set_cmd(32'd0, 32'd1, 1'b1, 8'd1);
    step("t8_accept", 1'b1, 1'b1, 1'b0, 32'd0, F_BUSY);
    step("t8_load",   1'b0, 1'b1, 1'b0, 32'd0, F_BUSY);
    step("t8_c1",     1'b0, 1'b1, 1'b0, 32'd1, F_BUSY);
    step("t8_done1",  1'b0, 1'b1, 1'b0, 32'd1, 5'b10110);
    step("t8_reload", 1'b0, 1'b1, 1'b0, 32'd0, F_BUSY);
    step("t8_c1b",    1'b0, 1'b1, 1'b0, 32'd1, F_BUSY);
    step("t8_done2",  1'b0, 1'b1, 1'b0, 32'd1, 5'b10110);
    step("t8_reload2",1'b0, 1'b1, 1'b0, 32'd0, F_BUSY);
    step("t8_abort",  1'b0, 1'b1, 1'b1, 32'd0, F_AB_IDLE);
    auto_reload = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
